resp_router: RTL and testbench

RESP_ROUTER -- requirements
Module: resp_router

---
 rtl/resp_router_if.sv | 32 +++
 rtl/resp_router.sv | 129 ++++++++++++
 tb/tb_resp_router.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/resp_router_if.sv
// Bundle between the requester-side arbiter, the downstream response channel and resp_router.
// The slave modport is the router; the master modport is whatever issues requests and delivers responses.
interface resp_router_if #(
    parameter int NUM_GROUP = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8
);
    // Handshake: issue_valid_i and resp_valid_i are valid-only strobes with no ready.
    // Each is sampled on every rising clk edge where it is high and is never stalled;
    // anything the router cannot accept is dropped and reported through err_o.
    // resp_valid_o is likewise a one-cycle valid toward the owning port with no back-pressure.
    logic                     issue_valid_i;
    logic [NUM_GROUP-1:0]     issue_grant_i;
    logic                     resp_valid_i;
    logic [DATA_W-1:0]        resp_data_i;
    logic                     err_clr_i;
    logic [NUM_GROUP-1:0]     resp_valid_o;
    logic [DATA_W-1:0]        resp_data_o;
    logic                     full_o;
    logic [$clog2(DEPTH):0]   outstanding_o;
    logic                     err_o;

    modport master (
        output issue_valid_i, issue_grant_i, resp_valid_i, resp_data_i, err_clr_i,
        input  resp_valid_o, resp_data_o, full_o, outstanding_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_grant_i, resp_valid_i, resp_data_i, err_clr_i,
        output resp_valid_o, resp_data_o, full_o, outstanding_o, err_o
    );
endinterface

// File: rtl/resp_router.sv
// In-order response router: a tag FIFO records which port owns each issued request and steers responses back.
// Optional macro RESP_ROUTER_REG_OUT_EN registers resp_valid_o/resp_data_o (1-cycle latency).
module resp_router #(
    parameter int NUM_GROUP = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    resp_router_if.slave  bus
);
    localparam int IDX_W = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     tag_mem [DEPTH];
    logic                 err_q;

    logic                 grant_onehot;
    logic [IDX_W-1:0]     grant_idx;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 err_set;
    logic [IDX_W-1:0]     head_idx;
    logic [NUM_GROUP-1:0] route_valid;
    logic [DATA_W-1:0]    route_data;

    always_comb begin
        grant_idx    = '0;
        grant_onehot = ($countones(bus.issue_grant_i) == 1);
        for (int g = 0; g < NUM_GROUP; g++) begin
            if (bus.issue_grant_i[g]) begin
                grant_idx = IDX_W'(g);
            end
        end
    end

    // Equal low bits with differing wrap bits means the write side has lapped the read side.
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Both decisions use the pre-edge state, so a same-cycle pop never frees room for a push.
    assign push_ok = bus.issue_valid_i && grant_onehot && !fifo_full;
    assign pop_ok  = bus.resp_valid_i && !fifo_empty;
    assign err_set = (bus.issue_valid_i && (!grant_onehot || fifo_full)) ||
                     (bus.resp_valid_i && fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            tag_mem[wr_ptr[PTR_W-1:0]] <= grant_idx;
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign head_idx = tag_mem[rd_ptr[PTR_W-1:0]];

    always_comb begin
        route_valid = '0;
        route_data  = '0;
        if (pop_ok) begin
            route_data = bus.resp_data_i;
            for (int g = 0; g < NUM_GROUP; g++) begin
                route_valid[g] = (head_idx == IDX_W'(g));
            end
        end
    end

`ifdef RESP_ROUTER_REG_OUT_EN
    logic [NUM_GROUP-1:0] resp_valid_q;
    logic [DATA_W-1:0]    resp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= route_valid;
            resp_data_q  <= route_data;
        end
    end

    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
`else
    assign bus.resp_valid_o = route_valid;
    assign bus.resp_data_o  = route_data;
`endif

    assign bus.outstanding_o = count;
    assign bus.full_o        = (count == CNT_W'(DEPTH));
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_resp_router.sv
// Self-checking bench for resp_router: directed scenarios plus a randomized run against a queue model.
// Works with or without RESP_ROUTER_REG_OUT_EN; routed outputs are sampled where each build presents them.
module tb_resp_router;
  localparam int NG = 4;
  localparam int DW = 16;
  localparam int DP = 8;

  logic clk;
  logic rst_n;

  resp_router_if #(.NUM_GROUP(NG), .DATA_W(DW), .DEPTH(DP)) bus ();

  resp_router #(.NUM_GROUP(NG), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: owning port of every outstanding request, oldest first
  logic [1:0]    exp_q[$];
  logic          model_err;
  logic [NG-1:0] exp_valid;
  logic [DW-1:0] exp_data;

  logic [NG-1:0] obs_valid;
  logic [DW-1:0] obs_data;
  logic [3:0]    obs_cnt;
  logic          obs_full;
  logic          obs_err;

  task automatic set_idle();
    bus.issue_valid_i = 1'b0;
    bus.issue_grant_i = '0;
    bus.resp_valid_i  = 1'b0;
    bus.resp_data_i   = '0;
    bus.err_clr_i     = 1'b0;
  endtask

  // driver: one clock of stimulus, entered and left at a falling edge; updates the model
  task automatic drive_cycle(input logic iv, input logic [NG-1:0] g, input logic rv,
                             input logic [DW-1:0] d, input logic clr);
    logic       oh;
    logic       was_full;
    logic       was_empty;
    logic [1:0] idx;
    bus.issue_valid_i = iv;
    bus.issue_grant_i = g;
    bus.resp_valid_i  = rv;
    bus.resp_data_i   = d;
    bus.err_clr_i     = clr;
    oh        = ($countones(g) == 1);
    was_full  = (exp_q.size() == DP);
    was_empty = (exp_q.size() == 0);
    exp_valid = '0;
    exp_data  = '0;
    if (rv && !was_empty) begin
      exp_valid = 4'b0001 << exp_q[0];
      exp_data  = d;
    end
    idx = 2'd0;
    for (int i = 0; i < NG; i++) if (g[i]) idx = i[1:0];
    #1;
`ifndef RESP_ROUTER_REG_OUT_EN
    obs_valid = bus.resp_valid_o;
    obs_data  = bus.resp_data_o;
`endif
    @(posedge clk);
    if (rv && !was_empty) void'(exp_q.pop_front());
    if (iv && oh && !was_full) exp_q.push_back(idx);
    if ((iv && !oh) || (iv && oh && was_full) || (rv && was_empty)) model_err = 1'b1;
    else if (clr) model_err = 1'b0;
    #1;
    obs_cnt  = bus.outstanding_o;
    obs_full = bus.full_o;
    obs_err  = bus.err_o;
`ifdef RESP_ROUTER_REG_OUT_EN
    obs_valid = bus.resp_valid_o;
    obs_data  = bus.resp_data_o;
`endif
    @(negedge clk);
    set_idle();
  endtask

  task automatic issue(input int port);
    drive_cycle(1'b1, 4'b0001 << port, 1'b0, '0, 1'b0);
  endtask

  task automatic respond(input logic [DW-1:0] d);
    drive_cycle(1'b0, '0, 1'b1, d, 1'b0);
  endtask

  task automatic clear_err();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    exp_q.delete();
    model_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 4'b0000 || bus.resp_data_o !== 16'h0000 ||
        bus.outstanding_o !== 4'd0 || bus.full_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h cnt=%0d full=%b err=%b, required all zero",
               bus.resp_valid_o, bus.resp_data_o, bus.outstanding_o, bus.full_o, bus.err_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_order();
    logic [NG-1:0] want_v [3];
    logic [DW-1:0] want_d [3];
    int ports [3];
    ports[0] = 2; ports[1] = 0; ports[2] = 3;
    want_v[0] = 4'b0100; want_v[1] = 4'b0001; want_v[2] = 4'b1000;
    want_d[0] = 16'hAAAA; want_d[1] = 16'hBBBB; want_d[2] = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      issue(ports[i]);
      checks++;
      if (obs_cnt !== 4'(i + 1)) begin
        errors++;
        $display("FAIL order_issue_cnt[%0d]: got %0d, required %0d", i, obs_cnt, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      respond(want_d[i]);
      checks++;
      if (obs_valid !== want_v[i] || obs_data !== want_d[i] || obs_cnt !== 4'(2 - i)) begin
        errors++;
        $display("FAIL order_resp[%0d]: valid=%b data=%h cnt=%0d, required valid=%b data=%h cnt=%0d",
                 i, obs_valid, obs_data, obs_cnt, want_v[i], want_d[i], 2 - i);
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DP; i++) issue(i % NG);
    checks++;
    if (obs_full !== 1'b1 || obs_cnt !== 4'd8 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL full_after_8: full=%b cnt=%0d err=%b, required full=1 cnt=8 err=0",
               obs_full, obs_cnt, obs_err);
    end
    issue(1);
    checks++;
    if (obs_full !== 1'b1 || obs_cnt !== 4'd8 || obs_err !== 1'b1) begin
      errors++;
      $display("FAIL full_reject_9th: full=%b cnt=%0d err=%b, required full=1 cnt=8 err=1",
               obs_full, obs_cnt, obs_err);
    end
    clear_err();
    for (int i = 0; i < DP; i++) begin
      respond(16'h1000 + 16'(i));
      checks++;
      if (obs_valid !== (4'b0001 << (i % NG)) || obs_data !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h, required valid=%b data=%h",
                 i, obs_valid, obs_data, 4'b0001 << (i % NG), 16'h1000 + 16'(i));
      end
    end
    checks++;
    if (obs_cnt !== 4'd0 || obs_full !== 1'b0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: cnt=%0d full=%b err=%b, required 0 0 0", obs_cnt, obs_full, obs_err);
    end
  endtask

  task automatic test_empty_err();
    respond(16'h5A5A);
    checks++;
    if (obs_valid !== 4'b0000 || obs_err !== 1'b1 || obs_cnt !== 4'd0) begin
      errors++;
      $display("FAIL empty_resp: valid=%b err=%b cnt=%0d, required valid=0000 err=1 cnt=0",
               obs_valid, obs_err, obs_cnt);
    end
    clear_err();
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, required 0", obs_err);
    end
    // clear coinciding with a new error keeps the flag set
    drive_cycle(1'b0, '0, 1'b1, 16'h0, 1'b1);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL err_clear_vs_set: got %b, required 1", obs_err);
    end
    clear_err();
  endtask

  task automatic test_back_to_back();
    logic [NG-1:0] want_v [4];
    for (int i = 0; i < 4; i++) issue(i);
    drive_cycle(1'b1, 4'b0100, 1'b1, 16'hD00D, 1'b0);
    checks++;
    if (obs_valid !== 4'b0001 || obs_data !== 16'hD00D || obs_cnt !== 4'd4) begin
      errors++;
      $display("FAIL simul_push_pop: valid=%b data=%h cnt=%0d, required valid=0001 data=d00d cnt=4",
               obs_valid, obs_data, obs_cnt);
    end
    want_v[0] = 4'b0010; want_v[1] = 4'b0100; want_v[2] = 4'b1000; want_v[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      respond(16'hE000 + 16'(i));
      checks++;
      if (obs_valid !== want_v[i]) begin
        errors++;
        $display("FAIL simul_drain[%0d]: valid=%b, required %b", i, obs_valid, want_v[i]);
      end
    end
  endtask

  task automatic test_bad_grant();
    issue(3);
    drive_cycle(1'b1, 4'b0110, 1'b0, '0, 1'b0);
    checks++;
    if (obs_cnt !== 4'd1 || obs_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_grant: cnt=%0d err=%b, required cnt=1 err=1", obs_cnt, obs_err);
    end
    clear_err();
    respond(16'h3333);
    checks++;
    if (obs_valid !== 4'b1000 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_grant_drain: valid=%b err=%b, required valid=1000 err=0", obs_valid, obs_err);
    end
  endtask

  task automatic test_reset_mid();
    issue(1); issue(2); issue(0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.outstanding_o !== 4'd0 || bus.resp_valid_o !== 4'b0000 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d valid=%b err=%b, required 0 0000 0",
               bus.outstanding_o, bus.resp_valid_o, bus.err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_err = 1'b0;
    respond(16'h7777);
    checks++;
    if (obs_valid !== 4'b0000 || obs_err !== 1'b1 || obs_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_drop: valid=%b err=%b cnt=%0d, required 0000 1 0",
               obs_valid, obs_err, obs_cnt);
    end
    clear_err();
  endtask

  task automatic test_random();
    logic          iv;
    logic          rv;
    logic          clr;
    logic [NG-1:0] g;
    logic [DW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 99) < 55);
      rv  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) g = 4'($urandom_range(0, 15));
      else g = 4'b0001 << $urandom_range(0, NG - 1);
      d = 16'($urandom);
      drive_cycle(iv, g, rv, d, clr);
      checks++;
      if (obs_valid !== exp_valid || (exp_valid != '0 && obs_data !== exp_data) ||
          obs_cnt !== 4'(exp_q.size()) || obs_full !== (exp_q.size() == DP) ||
          obs_err !== model_err) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b data=%h cnt=%0d full=%b err=%b, required valid=%b data=%h cnt=%0d full=%b err=%b",
                 n, obs_valid, obs_data, obs_cnt, obs_full, obs_err,
                 exp_valid, exp_data, exp_q.size(), (exp_q.size() == DP), model_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_empty_err();
    test_back_to_back();
    test_bad_grant();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
